axi_rd_ctrl: RTL and testbench
==============================

AXI_RD_CTRL -- requirements
Module: axi_rd_ctrl

Interface
REQ-001 SHALL have parameter AXI_WIDTH, 256, data width of the AXI read master and FIFO.
REQ-002 SHALL have parameter BURST_LEN, 8'd63, value driven on rd_len (beats-1).
REQ-003 SHALL have parameter ADDR_BASE, 29'd0, byte start address of frame buffer 0.
REQ-004 SHALL have parameter FRAME_BYTES, 29'd4147200, bytes per frame buffer, a multiple of burst bytes.
REQ-005 SHALL have parameter FIFO_DEPTH, 512, depth in words of the downstream read FIFO.
REQ-006 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset, asynchronous, active-low).
REQ-007 SHALL have ports enable in 1 (reading permitted) and frame_sync in 1 (pulse: restart at frame start).
REQ-008 SHALL have port fifo_wr_cnt in 10 (words currently held in the downstream FIFO).
REQ-009 SHALL have ports rd_ready in 1, rd_done in 1, rd_handshake in 1 and rd_data_in in AXI_WIDTH, all from the read master.
REQ-010 SHALL have ports rd_start out 1, rd_addr out 29 and rd_len out 8, all to the read master.
REQ-011 SHALL have ports fifo_wr_en out 1 and fifo_wr_data out AXI_WIDTH, to the FIFO.
REQ-012 SHALL have ports frame_done out 1 (pulse), busy out 1 and burst_err out 1 (sticky).

Function
REQ-013 SHALL implement states IDLE, CHECK, START, WAIT_DONE; the reset state is IDLE.
REQ-014 IDLE->CHECK SHALL occur when enable=1 and rd_ready=1.
REQ-015 CHECK->START SHALL occur when FIFO_DEPTH-fifo_wr_cnt >= BURST_LEN+1; otherwise CHECK->IDLE.
REQ-016 START SHALL assert rd_start for exactly one cycle, with rd_addr/rd_len stable from that cycle until rd_done; START->WAIT_DONE.
REQ-017 WAIT_DONE->IDLE SHALL occur on rd_done=1.
REQ-018 Address step SHALL be (BURST_LEN+1)*AXI_WIDTH/8 bytes, computed at 29 bits.
REQ-019 On rd_done, rd_addr SHALL advance by the step. If the result >= frame base+FRAME_BYTES, rd_addr SHALL wrap to the frame base and frame_done SHALL pulse for 1 cycle.
REQ-020 frame_sync SHALL set a pending flag. The flag SHALL be applied in IDLE or on rd_done, loading rd_addr with the frame base and overriding the advance; it never truncates an in-flight burst.
REQ-021 frame_sync and wrap on the same rd_done SHALL produce a single frame_done pulse.
REQ-022 fifo_wr_en/fifo_wr_data SHALL be rd_handshake/rd_data_in registered with 1-cycle latency, independent of state.
REQ-023 A beat counter SHALL count rd_handshake per burst and clear on rd_start.
REQ-024 If rd_done arrives with beat count != BURST_LEN+1, burst_err SHALL set and hold until reset.
REQ-025 busy SHALL be 1 in START and WAIT_DONE.
REQ-026 enable deasserting mid-burst SHALL let the current burst complete, then the block SHALL hold in IDLE.

Reset
REQ-027 On rst_n=0: state IDLE, rd_start 0, rd_addr ADDR_BASE, rd_len BURST_LEN, fifo_wr_en 0, fifo_wr_data 0, frame_done 0, busy 0, burst_err 0, pending flag 0, beat counter 0.
REQ-028 Reset mid-burst SHALL abandon the burst; the read master is reset by the same rst_n.

Configuration
REQ-029 With PING_PONG_EN defined, the block SHALL add input wr_buf_sel (1).
REQ-030 With PING_PONG_EN defined, the frame base SHALL be ADDR_BASE+FRAME_BYTES when wr_buf_sel=0, else ADDR_BASE, sampled at each frame start (wrap or applied frame_sync).
REQ-031 Without PING_PONG_EN, the frame base SHALL always be ADDR_BASE and wr_buf_sel SHALL be absent.

Structure
REQ-032 Package axi_ddr_pkg SHALL hold AXI_WIDTH, AXI_AXSIZE, the 29-bit address width, and the state enum/encodings.
REQ-033 The block SHALL be a single module with no sub-module; the beat counter and address generator are inline.

Verification
REQ-034 enable=1, fifo_wr_cnt=0, master model returns 64 beats: exactly one rd_start, rd_addr=0, rd_len=63, and 64 fifo_wr_en, each 1 cycle after its handshake.
REQ-035 fifo_wr_cnt=449: no rd_start. fifo_wr_cnt=448: rd_start issued.
REQ-036 FRAME_BYTES=4096, 2 bursts: second rd_addr=2048, then wrap to 0 with one frame_done pulse.
REQ-037 frame_sync mid-burst at rd_addr=2048: burst completes, next rd_addr=0, single frame_done.
REQ-038 Master model delivers 63 beats then rd_done: burst_err=1, and it persists until rst_n pulse.
REQ-039 PING_PONG_EN, wr_buf_sel=0 at wrap: next rd_addr=ADDR_BASE+FRAME_BYTES.

Source files
------------

// File: rtl/axi_ddr_pkg.sv
// Shared constants and read-controller FSM encoding for the DDR read path.
package axi_ddr_pkg;
  parameter int         AXI_WIDTH  = 256;
  parameter logic [2:0] AXI_AXSIZE = 3'($clog2(AXI_WIDTH / 8));
  parameter int         AXI_ADDR_W = 29;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } rd_state_t;
endpackage

// File: rtl/axi_rd_ctrl_if.sv
// Command and beat channel between axi_rd_ctrl (master) and the AXI read master engine (slave).
interface axi_rd_ctrl_if #(
  parameter int AXI_WIDTH = axi_ddr_pkg::AXI_WIDTH
) ();
  logic                                rd_ready;
  logic                                rd_done;
  logic                                rd_handshake;
  logic [AXI_WIDTH-1:0]                rd_data_in;
  logic                                rd_start;
  logic [axi_ddr_pkg::AXI_ADDR_W-1:0]  rd_addr;
  logic [7:0]                          rd_len;

  modport master (
    input  rd_ready, rd_done, rd_handshake, rd_data_in,
    output rd_start, rd_addr, rd_len
  );

  modport slave (
    output rd_ready, rd_done, rd_handshake, rd_data_in,
    input  rd_start, rd_addr, rd_len
  );
endinterface

// File: rtl/axi_rd_ctrl.sv
// Frame-buffer read burst controller: issues fixed-length bursts while the FIFO has room.
// Optional PING_PONG_EN adds wr_buf_sel to alternate between two frame buffers.
module axi_rd_ctrl
  import axi_ddr_pkg::*;
#(
  parameter int                    AXI_WIDTH   = axi_ddr_pkg::AXI_WIDTH,
  parameter logic [7:0]            BURST_LEN   = 8'd63,
  parameter logic [AXI_ADDR_W-1:0] ADDR_BASE   = 29'd0,
  parameter logic [AXI_ADDR_W-1:0] FRAME_BYTES = 29'd4147200,
  parameter int                    FIFO_DEPTH  = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 frame_sync,
  input  logic [9:0]           fifo_wr_cnt,
`ifdef PING_PONG_EN
  input  logic                 wr_buf_sel,
`endif
  axi_rd_ctrl_if.master        rd,
  output logic                 fifo_wr_en,
  output logic [AXI_WIDTH-1:0] fifo_wr_data,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 burst_err
);

  localparam logic [AXI_ADDR_W-1:0] STEP =
    AXI_ADDR_W'((int'(BURST_LEN) + 1) * (AXI_WIDTH / 8));
  localparam logic [9:0] BEATS = 10'(int'(BURST_LEN) + 1);

  rd_state_t             state;
  logic                  sync_pend;
  logic                  sync_req;
  logic                  room_ok;
  logic                  addr_wrap;
  logic [9:0]            beat_cnt;
  logic [9:0]            beat_total;
  logic [AXI_ADDR_W:0]   addr_adv;
  logic [AXI_ADDR_W:0]   frame_end;
  logic [AXI_ADDR_W-1:0] frame_base;
  logic [AXI_ADDR_W-1:0] next_base;

`ifdef PING_PONG_EN
  logic [AXI_ADDR_W-1:0] base_q;
  assign frame_base = base_q;
  assign next_base  = wr_buf_sel ? ADDR_BASE : ADDR_BASE + FRAME_BYTES;
`else
  assign frame_base = ADDR_BASE;
  assign next_base  = ADDR_BASE;
`endif

  // A sync arriving in the same cycle it could be applied is honoured immediately.
  assign sync_req   = sync_pend | frame_sync;
  assign room_ok    = (int'(fifo_wr_cnt) + int'(BURST_LEN) + 1) <= FIFO_DEPTH;
  assign beat_total = beat_cnt + 10'(rd.rd_handshake);
  assign addr_adv   = {1'b0, rd.rd_addr} + {1'b0, STEP};
  assign frame_end  = {1'b0, frame_base} + {1'b0, FRAME_BYTES};
  assign addr_wrap  = addr_adv >= frame_end;

  // Stage p0 -> p1: beats forwarded to the FIFO one cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en   <= rd.rd_handshake;
      fifo_wr_data <= rd.rd_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd.rd_start <= 1'b0;
      rd.rd_addr <= ADDR_BASE;
      rd.rd_len  <= BURST_LEN;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      burst_err  <= 1'b0;
      sync_pend  <= 1'b0;
      beat_cnt   <= '0;
`ifdef PING_PONG_EN
      base_q     <= ADDR_BASE;
`endif
    end else begin
      rd.rd_start <= 1'b0;
      rd.rd_len   <= BURST_LEN;
      frame_done  <= 1'b0;
      sync_pend   <= sync_req;

      if (rd.rd_start)
        beat_cnt <= 10'(rd.rd_handshake);
      else if (rd.rd_handshake)
        beat_cnt <= beat_cnt + 10'd1;

      case (state)
        IDLE: begin
          if (sync_req) begin
            rd.rd_addr <= next_base;
            sync_pend  <= 1'b0;
`ifdef PING_PONG_EN
            base_q     <= next_base;
`endif
          end
          if (enable && rd.rd_ready)
            state <= CHECK;
        end
        CHECK: begin
          if (room_ok) begin
            state       <= START;
            rd.rd_start <= 1'b1;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (rd.rd_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (beat_total != BEATS)
              burst_err <= 1'b1;
            // A pending sync and a natural wrap both start a new frame: one pulse.
            if (sync_req || addr_wrap) begin
              rd.rd_addr <= next_base;
              sync_pend  <= 1'b0;
              frame_done <= 1'b1;
`ifdef PING_PONG_EN
              base_q     <= next_base;
`endif
            end else begin
              rd.rd_addr <= addr_adv[AXI_ADDR_W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_ctrl.sv
// Randomized self-checking bench for axi_rd_ctrl with a behavioural address/frame model.
// Build with PING_PONG_EN defined to exercise the dual frame-buffer option.
module tb_axi_rd_ctrl;
  localparam int W    = 256;
  localparam int FB   = 4096;
  localparam int STEP = 64 * W / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_sync = 1'b0;
  logic [9:0]  fifo_wr_cnt = '0;
  logic        fifo_wr_en;
  logic [W-1:0] fifo_wr_data;
  logic        frame_done;
  logic        busy;
  logic        burst_err;
`ifdef PING_PONG_EN
  logic        wr_buf_sel = 1'b1;
`endif

  axi_rd_ctrl_if #(.AXI_WIDTH(W)) rd_bus ();

  axi_rd_ctrl #(
    .AXI_WIDTH  (W),
    .BURST_LEN  (8'd63),
    .ADDR_BASE  (29'd0),
    .FRAME_BYTES(29'd4096),
    .FIFO_DEPTH (512)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_sync  (frame_sync),
    .fifo_wr_cnt (fifo_wr_cnt),
`ifdef PING_PONG_EN
    .wr_buf_sel  (wr_buf_sel),
`endif
    .rd          (rd_bus),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .burst_err   (burst_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every sampled handshake must reappear on the FIFO port one cycle later.
  logic         hs_q  = 1'b0;
  logic [W-1:0] dat_q = '0;
  int           fd_cnt = 0;
  int           start_cnt = 0;

  always @(posedge clk) begin
    hs_q  = rst_n & rd_bus.rd_handshake;
    dat_q = rd_bus.rd_data_in;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("fifo_wr_en", W'(fifo_wr_en), W'(hs_q));
      if (hs_q) check("fifo_wr_data", fifo_wr_data, dat_q);
      if (frame_done) fd_cnt++;
      if (rd_bus.rd_start) start_cnt++;
    end
  end

  // Reference model: frame buffer address sequence from the rules, in plain integers.
  int exp_addr = 0;
  int exp_base = 0;
  bit exp_err  = 1'b0;

  function automatic int base_now();
`ifdef PING_PONG_EN
    return wr_buf_sel ? 0 : FB;
`else
    return 0;
`endif
  endfunction

  task automatic model_done(input int nbeats, input bit synced, output int exp_fd);
    int nxt;
    exp_fd = 0;
    if (nbeats != 64) exp_err = 1'b1;
    nxt = exp_addr + STEP;
    if (synced || nxt >= exp_base + FB) begin
      exp_base = base_now();
      exp_addr = exp_base;
      exp_fd   = 1;
    end else begin
      exp_addr = nxt;
    end
  endtask

  // Read master model: waits for rd_start, returns nbeats with random gaps, then rd_done.
  task automatic serve_burst(input int nbeats, input int sync_at,
                             output logic [28:0] addr, output bit ok);
    int t = 0;
    ok = 1'b0;
    addr = '0;
    while (rd_bus.rd_start !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    if (rd_bus.rd_start !== 1'b1) begin
      check("start_timeout", 0, 1);
      return;
    end
    ok   = 1'b1;
    addr = rd_bus.rd_addr;
    check("rd_len", W'(rd_bus.rd_len), 63);
    check("busy_start", W'(busy), 1);
    enable = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        rd_bus.rd_handshake = 1'b0;
        frame_sync = (b == sync_at) && (g == 0);
        tick();
      end
      frame_sync = 1'b0;
      rd_bus.rd_handshake = 1'b1;
      for (int k = 0; k < W / 32; k++) rd_bus.rd_data_in[k*32 +: 32] = $urandom();
      tick();
    end
    rd_bus.rd_handshake = 1'b0;
    check("addr_stable", W'(rd_bus.rd_addr), W'(addr));
    check("busy_wait", W'(busy), 1);
    rd_bus.rd_done = 1'b1;
    tick();
    rd_bus.rd_done = 1'b0;
    tick(3);
  endtask

  task automatic run_burst(input string tag, input int nbeats, input int sync_at);
    logic [28:0] a;
    bit ok;
    int fd0, s0, efd;
    fd0 = fd_cnt;
    s0  = start_cnt;
    enable = 1'b1;
    serve_burst(nbeats, sync_at, a, ok);
    if (ok) begin
      check({tag, "_addr"}, W'(a), W'(exp_addr));
      model_done(nbeats, sync_at >= 0, efd);
      check({tag, "_next"}, W'(rd_bus.rd_addr), W'(exp_addr));
      check({tag, "_frame_done"}, W'(fd_cnt - fd0), W'(efd));
      check({tag, "_starts"}, W'(start_cnt - s0), 1);
      check({tag, "_err"}, W'(burst_err), W'(exp_err));
      check({tag, "_busy_end"}, W'(busy), 0);
    end
  endtask

  task automatic expect_no_start(input string tag);
    int s0;
    s0 = start_cnt;
    enable = 1'b1;
    tick(30);
    check({tag, "_starts"}, W'(start_cnt - s0), 0);
    check({tag, "_busy"}, W'(busy), 0);
    enable = 1'b0;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rd_bus.rd_ready     = 1'b1;
    rd_bus.rd_done      = 1'b0;
    rd_bus.rd_handshake = 1'b0;
    rd_bus.rd_data_in   = '0;
    tick(3);
    check("rst_rd_start", W'(rd_bus.rd_start), 0);
    check("rst_rd_addr", W'(rd_bus.rd_addr), 0);
    check("rst_rd_len", W'(rd_bus.rd_len), 63);
    check("rst_fifo_wr_en", W'(fifo_wr_en), 0);
    check("rst_fifo_wr_data", fifo_wr_data, 0);
    check("rst_frame_done", W'(frame_done), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_burst_err", W'(burst_err), 0);
    rst_n = 1'b1;
    tick(2);

    fifo_wr_cnt = 10'd0;
    run_burst("first", 64, -1);
    fifo_wr_cnt = 10'd449;
    expect_no_start("cnt449");
    fifo_wr_cnt = 10'd1023;
    expect_no_start("cnt1023");
    fifo_wr_cnt = 10'd448;
    run_burst("cnt448_wrap", 64, -1);
    run_burst("b3", 64, -1);
    run_burst("sync_wrap", 64, 20);
    run_burst("sync_mid0", 64, 30);
    run_burst("b4", 64, -1);

    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick(2);
    exp_base = base_now();
    exp_addr = exp_base;
    check("idle_sync_addr", W'(rd_bus.rd_addr), W'(exp_addr));

`ifdef PING_PONG_EN
    run_burst("pp_a", 64, -1);
    wr_buf_sel = 1'b0;
    run_burst("pp_wrap", 64, -1);
    wr_buf_sel = 1'b1;
    run_burst("pp_b", 64, -1);
    run_burst("pp_back", 64, -1);
`endif

    for (int i = 0; i < 12; i++) begin
      cnt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(449, 1023))
                                         : int'($urandom_range(0, 460));
      fifo_wr_cnt = 10'(cnt);
      if (cnt + 64 <= 512)
        run_burst("rand", 64, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 62)) : -1);
      else
        expect_no_start("rand_full");
    end

    fifo_wr_cnt = 10'd0;
    run_burst("short", 63, -1);
    run_burst("err_hold", 64, -1);
    rst_n = 1'b0;
    tick(2);
    check("err_reset", W'(burst_err), 0);
    check("err_reset_addr", W'(rd_bus.rd_addr), 0);
    rst_n = 1'b1;
    exp_addr = 0;
    exp_base = 0;
    exp_err  = 1'b0;
`ifdef PING_PONG_EN
    wr_buf_sel = 1'b1;
`endif
    tick(2);
    run_burst("post_reset", 64, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
